// File: rtl/apb_master_bridge_if.sv
// Command/response stream and APB bus signals of apb_master_bridge.
// The master modport is the bridge view; the slave modport is the view of the command source and APB target.
interface apb_master_bridge_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Valid/ready command stream to single APB transfers (IDLE -> SETUP -> ACCESS) with a one-cycle response pulse.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without pready.
module apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 pclk,
  input  logic                 presetn,
  apb_master_bridge_if.master  bus,
  output logic                 busy
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be at least 1");
  end

  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != S_IDLE);

  // Next-state and registered-output computation for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (bus.cmd_valid) begin
          // Write data is captured for reads too; it is simply unused by the target.
          pwrite_d = bus.cmd_write;
          paddr_d  = bus.cmd_addr;
          pwdata_d = bus.cmd_wdata;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = S_ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_ACCESS: begin
        if (bus.pready) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.pslverr;
          rsp_rdata_d = pwrite_q ? rsp_rdata_q : bus.prdata;
          state_d     = S_IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
        end else if (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // This edge would be the TIMEOUT_CYCLES-th ACCESS cycle without pready.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
          state_d   = S_ACCESS;
        end
`else
        end else begin
          state_d = S_ACCESS;
        end
`endif
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight transfer silently.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: vector table, hand-written corner sequences and random traffic vs a memory model.
module tb_apb_master_bridge;
  logic pclk;
  logic presetn;
  logic busy;

  apb_master_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  apb_master_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus),
    .busy    (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // APB target: memory with programmable wait states, error above address 200, noise outside ACCESS.
  logic [31:0] slave_mem [256];
  int          slave_waits = 0;
  int          s_wcnt;
  bit          s_done;

  always @(negedge pclk or negedge presetn) begin
    if (!presetn) begin
      bus.pready  = 1'b0;
      bus.pslverr = 1'b0;
      bus.prdata  = 32'h0;
      s_wcnt      = 0;
      s_done      = 1'b0;
    end else if (bus.psel && bus.penable) begin
      if (s_done) begin
        bus.pready = 1'b0;
      end else if (s_wcnt >= slave_waits) begin
        bus.pready  = 1'b1;
        s_done      = 1'b1;
        bus.pslverr = (bus.paddr > 8'd200);
        bus.prdata  = bus.pslverr ? 32'h0 : slave_mem[bus.paddr];
        if (bus.pwrite && !bus.pslverr) slave_mem[bus.paddr] = bus.pwdata;
      end else begin
        bus.pready  = 1'b0;
        bus.pslverr = 1'($urandom);
        bus.prdata  = $urandom;
        s_wcnt++;
      end
    end else begin
      bus.pready  = 1'($urandom);
      bus.pslverr = 1'($urandom);
      bus.prdata  = $urandom;
      s_wcnt      = 0;
      s_done      = 1'b0;
    end
  end

  // Reference model: what the response of each transfer must be.
  logic [31:0] ref_mem [256];
  logic [31:0] last_rdata = 32'h0;

  function automatic void model_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d,
                                     output logic er, output logic [31:0] rd);
    er = (a > 8'd200);
    if (wr) begin
      if (!er) ref_mem[a] = d;
      rd = last_rdata;
    end else begin
      rd = er ? 32'h0 : ref_mem[a];
    end
    last_rdata = rd;
  endfunction

  // One full transfer with protocol checks; returns response and number of penable cycles.
  task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d, input int waits,
                        output logic [31:0] rd, output logic er, output int pen_cycles);
    bit got;
    bit stable;
    int cyc;
    slave_waits = waits;
    rd = 32'h0;
    er = 1'b0;
    @(negedge pclk);
    check("ready_before_cmd", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    @(posedge pclk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 8'($urandom);
    bus.cmd_wdata = $urandom;
    @(negedge pclk);
    check("setup_phase", {bus.psel, bus.penable, busy, bus.cmd_ready}, 4'b1010);
    got = 1'b0;
    stable = 1'b1;
    pen_cycles = 0;
    cyc = 0;
    while (!got && cyc < 200) begin
      @(negedge pclk);
      cyc++;
      bus.cmd_valid = 1'($urandom);
      if (bus.rsp_valid) begin
        got = 1'b1;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
        bus.cmd_valid = 1'b0;
        check("psel_drop_on_rsp", {bus.psel, bus.penable}, 2'b00);
      end else begin
        if (bus.penable) pen_cycles++;
        if (bus.paddr !== a || bus.pwrite !== wr || bus.pwdata !== d || bus.psel !== 1'b1) stable = 1'b0;
      end
    end
    bus.cmd_valid = 1'b0;
    check("rsp_seen", got, 1'b1);
    check("access_hold", stable, 1'b1);
    @(negedge pclk);
    check("rsp_single_pulse", {bus.rsp_valid, bus.psel}, 2'b00);
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        tbl [10];
  logic [31:0] rd, m_rd;
  logic        er, m_er;
  int          pen;

  initial begin
    tbl[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 8'h10, 32'h0,        0, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 8'hC9, 32'h0,        0, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 8'hC8, 32'h5A5A5A5A, 0, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 8'hC8, 32'h0,        1, 1'b0, 32'h5A5A5A5A};
    tbl[5] = '{1'b1, 8'h20, 32'hCAFEF00D, 5, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 8'h20, 32'h0,        5, 1'b0, 32'hCAFEF00D};
    tbl[7] = '{1'b1, 8'hFF, 32'h12345678, 2, 1'b1, 32'h0};
    tbl[8] = '{1'b0, 8'hFF, 32'h0,        0, 1'b1, 32'h0};
    tbl[9] = '{1'b0, 8'h00, 32'h0,        3, 1'b0, 32'h0};
    for (int i = 0; i < 256; i++) begin
      slave_mem[i] = 32'h0;
      ref_mem[i]   = 32'h0;
    end
    presetn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h0;
    bus.cmd_wdata = 32'h0;
    #12;
    check("reset_outputs",
          {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, busy},
          64'h0);
    check("reset_cmd_ready", bus.cmd_ready, 1'b1);
    @(negedge pclk);
    presetn = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 10; i++) begin
      model_xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, m_er, m_rd);
      do_cmd(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].waits, rd, er, pen);
      check($sformatf("vec%0d_err", i), er, tbl[i].exp_err);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].wr ? m_rd : tbl[i].exp_rdata);
      check($sformatf("vec%0d_penable_cycles", i), pen, tbl[i].waits + 1);
    end

    // cmd_valid held high over three commands: one IDLE cycle between transfers, 3 cycles each.
    begin
      logic        q_wr [3];
      logic [7:0]  q_a  [3];
      logic [31:0] q_d  [3];
      int idx, rsp_cnt, accepted, psel_cycles, done_cyc;
      bit idle_ok;
      q_wr = '{1'b1, 1'b1, 1'b0};
      q_a  = '{8'h01, 8'h02, 8'h01};
      q_d  = '{32'h11, 32'h22, 32'h0};
      for (int k = 0; k < 3; k++) model_xfer(q_wr[k], q_a[k], q_d[k], m_er, m_rd);
      slave_waits = 0;
      idx = 0; rsp_cnt = 0; accepted = 0; psel_cycles = 0; done_cyc = -1; idle_ok = 1'b1;
      @(negedge pclk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = q_wr[0];
      bus.cmd_addr  = q_a[0];
      bus.cmd_wdata = q_d[0];
      for (int c = 0; c < 60 && rsp_cnt < 3; c++) begin
        if (bus.rsp_valid) begin
          rsp_cnt++;
          rd = bus.rsp_rdata;
          if (rsp_cnt == 3) done_cyc = c;
        end
        if (bus.cmd_ready && bus.psel) idle_ok = 1'b0;
        if (bus.psel) psel_cycles++;
        if (bus.cmd_valid && bus.cmd_ready) begin
          accepted++;
          idx++;
          @(posedge pclk);
          #1;
          if (idx < 3) begin
            bus.cmd_write = q_wr[idx];
            bus.cmd_addr  = q_a[idx];
            bus.cmd_wdata = q_d[idx];
          end else begin
            bus.cmd_valid = 1'b0;
          end
        end
        @(negedge pclk);
      end
      bus.cmd_valid = 1'b0;
      check("b2b_accepted", accepted, 3);
      check("b2b_rsp_count", rsp_cnt, 3);
      check("b2b_final_rdata", rd, m_rd);
      check("b2b_idle_gap", idle_ok, 1'b1);
      check("b2b_psel_cycles", psel_cycles, 6);
      check("b2b_period", done_cyc, 9);
    end

    // Random traffic against the model.
    for (int i = 0; i < 40; i++) begin
      logic        r_wr;
      logic [7:0]  r_a;
      logic [31:0] r_d;
      int          r_w;
      r_wr = 1'($urandom_range(0, 1));
      r_a  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(201, 255)) : 8'($urandom_range(0, 31));
      r_d  = $urandom;
      r_w  = $urandom_range(0, 3);
      model_xfer(r_wr, r_a, r_d, m_er, m_rd);
      do_cmd(r_wr, r_a, r_d, r_w, rd, er, pen);
      if (er !== m_er || rd !== m_rd || pen != r_w + 1) begin
        check($sformatf("rand%0d_a%0h_w%0d", i, r_a, r_wr), {er, rd, 8'(pen)}, {m_er, m_rd, 8'(r_w + 1)});
      end else begin
        checks++;
      end
    end

    // Asynchronous reset in the middle of ACCESS.
    begin
      int seen;
      slave_waits = 1000;
      @(negedge pclk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 8'h10;
      bus.cmd_wdata = 32'hA5A5A5A5;
      @(posedge pclk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (4) @(negedge pclk);
      check("pre_reset_access", {bus.psel, bus.penable, busy}, 3'b111);
      #2;
      presetn = 1'b0;
      #1;
      check("async_reset_outputs",
            {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, busy},
            64'h0);
      @(negedge pclk);
      presetn = 1'b1;
      last_rdata = 32'h0;
      seen = 0;
      repeat (5) begin
        @(negedge pclk);
        if (bus.rsp_valid) seen++;
      end
      check("no_rsp_after_reset", seen, 0);
      model_xfer(1'b0, 8'h10, 32'h0, m_er, m_rd);
      do_cmd(1'b0, 8'h10, 32'h0, 0, rd, er, pen);
      check("post_reset_read", {er, rd}, {m_er, m_rd});
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Target never answers: abort after 16 ACCESS cycles.
    do_cmd(1'b0, 8'h10, 32'h0, 1000, rd, er, pen);
    last_rdata = 32'h0;
    check("timeout_err", er, 1'b1);
    check("timeout_rdata", rd, 32'h0);
    check("timeout_access_cycles", pen, 16);
`else
    // Target never answers: bridge waits in ACCESS indefinitely.
    begin
      int seen;
      slave_waits = 1000;
      seen = 0;
      @(negedge pclk);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 8'h10;
      @(posedge pclk);
      #1;
      bus.cmd_valid = 1'b0;
      repeat (40) begin
        @(negedge pclk);
        if (bus.rsp_valid) seen++;
      end
      check("no_timeout_no_rsp", seen, 0);
      check("no_timeout_still_access", {bus.psel, bus.penable, busy}, 3'b111);
      presetn = 1'b0;
      @(negedge pclk);
      presetn = 1'b1;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
